query_streamer: RTL and testbench

- Transmit side of the query-symbol interface: fetches a packed query sequence from the query SRAM and streams it one base per cycle as {valid, base[1:0]} symbols into the query buffer in front of the PE array.
- Frames each query with pouring_o, holds each symbol under full_i backpressure, and reports completion to the top-level controller.

---
 rtl/query_streamer.sv | 219 +++++++++++++++++++++
 tb/tb_query_streamer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_streamer.sv
// query_streamer
//
// Transmit side of the query-symbol interface. A packed query (2 bits per
// base, 16 bases per 32-bit word, base k in bits [2k+1:2k]) is read from the
// query SRAM and streamed one base per cycle into the query buffer as
// {valid, base[1:0]} symbols. The query is framed by pouring_o, each symbol
// is held under full_i backpressure, and completion is pulsed on done_o.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        one-cycle request, only honoured in IDLE
//   base_addr_i    word address of the first base (sampled with start_i)
//   length_i       number of bases (sampled with start_i)
//   abort_i        synchronous abort of the query in flight
//   busy_o         high while the streamer is not IDLE
//   done_o         one-cycle pulse after the last symbol is accepted
//   mem_ren_o      SRAM read enable
//   mem_addr_o     SRAM read address
//   mem_rdata_i    SRAM read data, valid one cycle after mem_ren_o
//   q_o            symbol: [2]=valid, [1:0]=base
//   pouring_o      high while the query is in flight
//   full_i         receiver full, the symbol on q_o is not taken this cycle
module query_streamer #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  length_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic [2:0]        q_o,
    output logic              pouring_o,
    input  logic              full_i
);

    localparam int BASES_PER_WORD = WORD_W / 2;
    localparam int CNT_W          = $clog2(BASES_PER_WORD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [LEN_W-1:0]    remaining, remaining_n;
    logic [WORD_W-1:0]   shift, shift_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [WORD_W-1:0]   pf_word, pf_word_n;
    logic                pf_valid, pf_valid_n;
    logic                pf_pending, pf_pending_n;
    logic [2:0]          q_r, q_n;
    logic                pouring_r, pouring_n;
    logic                rd_issue;
    logic                accept;
    logic                more_words;

    // Number of bases the next word contributes, given how many are still owed.
    function automatic logic [CNT_W-1:0] word_bases(input logic [LEN_W-1:0] left);
        if (left >= LEN_W'(BASES_PER_WORD))
            return CNT_W'(BASES_PER_WORD);
        else
            return CNT_W'(left);
    endfunction

    assign accept     = q_r[2] && !full_i;
    // Bases beyond the current word are still owed, so another word is needed.
    assign more_words = remaining > LEN_W'(cnt);

    // State and datapath registers; reset drops any query in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            remaining  <= '0;
            shift      <= '0;
            cnt        <= '0;
            pf_word    <= '0;
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
            q_r        <= 3'b000;
            pouring_r  <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            remaining  <= remaining_n;
            shift      <= shift_n;
            cnt        <= cnt_n;
            pf_word    <= pf_word_n;
            pf_valid   <= pf_valid_n;
            pf_pending <= pf_pending_n;
            q_r        <= q_n;
            pouring_r  <= pouring_n;
        end
    end

    // Next-state logic. cnt holds the bases left in the current word; when it
    // runs out the prefetched word (or one arriving this very cycle) is
    // swapped in so a full-rate stream has no bubble. q_o and pouring_o are
    // computed from the next state so they come straight out of flops.
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        remaining_n  = remaining;
        shift_n      = shift;
        cnt_n        = cnt;
        pf_word_n    = pf_word;
        pf_valid_n   = pf_valid;
        pf_pending_n = 1'b0;
        rd_issue     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        state_n     = S_FETCH;
                        addr_n      = base_addr_i;
                        remaining_n = length_i;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end

            S_FETCH: begin
                rd_issue = 1'b1;
                addr_n   = addr + ADDR_W'(1);
                state_n  = S_WAIT;
            end

            S_WAIT: begin
                shift_n = mem_rdata_i;
                cnt_n   = word_bases(remaining);
                state_n = S_STREAM;
            end

            S_STREAM: begin
                if (!pf_valid && !pf_pending && more_words) begin
                    rd_issue     = 1'b1;
                    addr_n       = addr + ADDR_W'(1);
                    pf_pending_n = 1'b1;
                end

                if (accept) begin
                    remaining_n = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else if (cnt > CNT_W'(1)) begin
                        shift_n = shift >> 2;
                        cnt_n   = cnt - CNT_W'(1);
                    end else if (pf_valid) begin
                        shift_n    = pf_word;
                        cnt_n      = word_bases(remaining - LEN_W'(1));
                        pf_valid_n = 1'b0;
                    end else if (pf_pending) begin
                        shift_n = mem_rdata_i;
                        cnt_n   = word_bases(remaining - LEN_W'(1));
                    end else begin
                        cnt_n = '0;
                    end
                    if (pf_pending && cnt > CNT_W'(1)) begin
                        pf_word_n  = mem_rdata_i;
                        pf_valid_n = 1'b1;
                    end
                end else if (cnt == '0) begin
                    // Fetch bubble: the returning word goes straight to current.
                    if (pf_pending) begin
                        shift_n = mem_rdata_i;
                        cnt_n   = word_bases(remaining);
                    end
                end else if (pf_pending) begin
                    pf_word_n  = mem_rdata_i;
                    pf_valid_n = 1'b1;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort wins over everything, including an acceptance this cycle.
        if (abort_i && state != S_IDLE) begin
            state_n      = S_IDLE;
            addr_n       = addr;
            cnt_n        = '0;
            pf_valid_n   = 1'b0;
            pf_pending_n = 1'b0;
            rd_issue     = 1'b0;
        end

        pouring_n = (state_n == S_STREAM);
        q_n       = (state_n == S_STREAM && cnt_n != '0) ? {1'b1, shift_n[1:0]} : 3'b000;
    end

    assign busy_o     = (state != S_IDLE);
    assign done_o     = (state == S_DONE);
    assign mem_ren_o  = rd_issue;
    assign mem_addr_o = addr;
    assign q_o        = q_r;
    assign pouring_o  = pouring_r;

endmodule

// File: tb/tb_query_streamer.sv
// Self-checking bench for query_streamer: an SRAM model answers reads one
// cycle later, expected bases are queued when a query is launched and popped
// as the DUT transfers symbols, and per-query timing/read checks follow.
module tb_query_streamer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [11:0] length_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic        mem_ren_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic [2:0]  q_o;
    logic        pouring_o;
    logic        full_i;

    query_streamer #(.WORD_W(32), .ADDR_W(10), .LEN_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .length_i   (length_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .mem_ren_o  (mem_ren_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
        .q_o        (q_o),
        .pouring_o  (pouring_o),
        .full_i     (full_i)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [11:0] len;
        bit          use_fill;
        logic [31:0] fill;
        int          stall_at;
        int          stall_len;
        int          extra_start;
        int          exp_reads;
        int          exp_done;
    } vec_t;

    logic [31:0] sram [0:1023];
    logic [1:0]  sb [$];
    logic [9:0]  rd_log [$];
    int          rd_cyc [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int acc_count, done_count, done_cyc, first_valid_cyc, last_acc_cyc;
    int pour_rises, pour_falls, pour_rise_cyc, pour_fall_cyc;
    logic       prev_stall, prev_abort, prev_pour;
    logic [2:0] prev_q;
    logic [1:0] exp_base;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SRAM model: data for a read shows up one cycle later, noise otherwise.
    always @(posedge clk) begin
        if (mem_ren_o) mem_rdata_i <= sram[mem_addr_o];
        else           mem_rdata_i <= $urandom;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ren_o) begin
                rd_log.push_back(mem_addr_o);
                rd_cyc.push_back(cyc);
            end
            if (done_o) begin
                done_count++;
                done_cyc = cyc;
            end
            if (pouring_o && !prev_pour) begin
                pour_rises++;
                pour_rise_cyc = cyc;
            end
            if (!pouring_o && prev_pour) begin
                pour_falls++;
                pour_fall_cyc = cyc;
            end
            if (q_o[2]) checkOutput("pour_with_valid", pouring_o, 1);
            if (prev_stall && !prev_abort) checkOutput("stall_hold", q_o, prev_q);
            if (q_o[2] && !full_i && !abort_i) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                last_acc_cyc = cyc;
                acc_count++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_symbol", q_o, 0);
                end else begin
                    exp_base = sb.pop_front();
                    checkOutput("symbol", q_o, {1'b1, exp_base});
                end
            end
            prev_stall = q_o[2] && full_i;
            prev_abort = abort_i;
            prev_q     = q_o;
            prev_pour  = pouring_o;
        end else begin
            prev_stall = 1'b0;
            prev_abort = 1'b0;
            prev_pour  = 1'b0;
        end
    end

    task automatic resetLogs();
        rd_log.delete();
        rd_cyc.delete();
        acc_count       = 0;
        done_count      = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        last_acc_cyc    = -1;
        pour_rises      = 0;
        pour_falls      = 0;
        pour_rise_cyc   = -1;
        pour_fall_cyc   = -1;
    endtask

    task automatic pushExpected(input logic [9:0] addr, input int len);
        logic [31:0] w;
        logic [9:0]  wa;
        for (int i = 0; i < len; i++) begin
            wa = addr + 10'(i / 16);
            w  = sram[wa];
            sb.push_back(w[2*(i%16) +: 2]);
        end
    endtask

    // Launch one query at the current cycle; returns the start cycle.
    task automatic launch(input logic [9:0] addr, input logic [11:0] len, output int t0);
        @(posedge clk); #1;
        start_i     = 1'b1;
        base_addr_i = addr;
        length_i    = len;
        t0          = cyc;
        @(posedge clk); #1;
        start_i     = 1'b0;
        base_addr_i = 10'($urandom);
        length_i    = 12'($urandom);
    endtask

    task automatic applyStimulus(input vec_t v);
        int t0;
        int stall_left;
        logic [9:0] exp_addr;
        if (v.use_fill)
            for (int i = 0; i < v.exp_reads; i++) sram[v.addr + 10'(i)] = v.fill;
        resetLogs();
        sb.delete();
        pushExpected(v.addr, int'(v.len));
        launch(v.addr, v.len, t0);
        checkOutput("busy_after_start", busy_o, 1);
        stall_left = v.stall_len;
        for (int k = 1; k < 2000; k++) begin
            if (done_count > 0) break;
            full_i = (acc_count == v.stall_at && stall_left > 0);
            if (full_i) stall_left--;
            if (k == v.extra_start) begin
                start_i     = 1'b1;
                base_addr_i = v.addr + 10'd300;
                length_i    = 12'd5;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        full_i  = 1'b0;
        start_i = 1'b0;
        checkOutput("done_seen", done_count > 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("done_count", done_count, 1);
        checkOutput("done_latency", done_cyc - t0, v.exp_done);
        checkOutput("first_valid_latency", first_valid_cyc - t0, 3);
        checkOutput("last_accept_latency", last_acc_cyc - t0, int'(v.len) + 2 + v.stall_len);
        checkOutput("pour_rise", pour_rise_cyc, first_valid_cyc);
        checkOutput("pour_fall", pour_fall_cyc, done_cyc);
        checkOutput("pour_falls", pour_falls, 1);
        checkOutput("accepted", acc_count, int'(v.len));
        checkOutput("sb_left", sb.size(), 0);
        checkOutput("read_count", rd_log.size(), v.exp_reads);
        if (rd_cyc.size() > 0) checkOutput("first_read_latency", rd_cyc[0] - t0, 1);
        for (int i = 0; i < rd_log.size(); i++) begin
            exp_addr = v.addr + 10'(i);
            checkOutput("read_addr", rd_log[i], exp_addr);
        end
        checkOutput("busy_after_done", busy_o, 0);
    endtask

    initial begin
        int t0;
        logic [31:0] rv;

        vecs[0] = '{10'd5,    12'd16, 1'b1, 32'hE4E4E4E4, -1, 0, 0, 1, 19};
        vecs[1] = '{10'd100,  12'd35, 1'b0, 32'h0,        -1, 0, 0, 3, 38};
        vecs[2] = '{10'd200,  12'd20, 1'b0, 32'h0,         7, 5, 0, 2, 28};
        vecs[3] = '{10'd1022, 12'd40, 1'b0, 32'h0,        -1, 0, 6, 3, 43};
        vecs[4] = '{10'd300,  12'd1,  1'b0, 32'h0,        -1, 0, 4, 1, 4};
        vecs[5] = '{10'd400,  12'd17, 1'b0, 32'h0,        16, 3, 0, 2, 23};

        for (int i = 0; i < 1024; i++) begin
            rv = $urandom;
            sram[i] = rv;
        end

        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        length_i    = '0;
        abort_i     = 1'b0;
        full_i      = 1'b0;
        prev_stall  = 1'b0;
        prev_abort  = 1'b0;
        prev_pour   = 1'b0;
        prev_q      = 3'b000;
        resetLogs();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_q", q_o, 0);
        checkOutput("reset_pouring", pouring_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_done", done_o, 0);
        checkOutput("reset_ren", mem_ren_o, 0);
        checkOutput("reset_addr", mem_addr_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Zero-length query: done pulse next cycle, no read, no framing.
        resetLogs();
        sb.delete();
        launch(10'd900, 12'd0, t0);
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("len0_done_count", done_count, 1);
        checkOutput("len0_done_latency", done_cyc - t0, 1);
        checkOutput("len0_reads", rd_log.size(), 0);
        checkOutput("len0_pour_rises", pour_rises, 0);
        checkOutput("len0_busy", busy_o, 0);

        // Abort on symbol 9 of 30, then a clean query afterwards.
        resetLogs();
        sb.delete();
        pushExpected(10'd150, 30);
        launch(10'd150, 12'd30, t0);
        for (int k = 0; k < 200 && acc_count != 9; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_reach", acc_count, 9);
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        checkOutput("abort_q", q_o, 0);
        checkOutput("abort_pouring", pouring_o, 0);
        checkOutput("abort_busy", busy_o, 0);
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("abort_no_done", done_count, 0);
        checkOutput("abort_accepted", acc_count, 9);
        sb.delete();
        applyStimulus(vecs[1]);

        // Asynchronous reset in the middle of a 40-base query.
        resetLogs();
        sb.delete();
        pushExpected(10'd60, 40);
        launch(10'd60, 12'd40, t0);
        for (int k = 0; k < 200 && acc_count != 10; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_reach", acc_count, 10);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_q", q_o, 0);
        checkOutput("rst_mid_pouring", pouring_o, 0);
        checkOutput("rst_mid_busy", busy_o, 0);
        checkOutput("rst_mid_ren", mem_ren_o, 0);
        checkOutput("rst_mid_addr", mem_addr_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        applyStimulus(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
